// File: rtl/bcd_pkg.sv
// Shared definitions for the BCD entry path: sign nibble codes, word geometry,
// range limits, FSM state encoding and the FIX-stage result evaluation.
// The bits generator uses the same sign constants.
package bcd_pkg;

  localparam logic [3:0]  SIGN_NEG  = 4'hA;
  localparam logic [3:0]  SIGN_POS  = 4'hF;
  localparam logic [3:0]  DIGIT_MAX = 4'd9;
  localparam int unsigned NDIG      = 3;

  localparam logic [9:0] S_POS_MAX = 10'd127;
  localparam logic [9:0] S_NEG_MAX = 10'd128;
  localparam logic [9:0] U_MAX     = 10'd255;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  typedef struct packed {
    logic [7:0] number;
    logic       err;
    logic       ovf;
  } result_t;

  // Priority-ordered classification of an accumulated word; the first
  // matching rule wins and a flagged result always carries number 0.
  function automatic result_t fix_result(input logic [9:0] acc,
                                         input logic [3:0] sign,
                                         input logic       signed_mode,
                                         input logic       bad);
    result_t res;
    logic    neg;
    logic    sign_ok;
    res     = '0;
    neg     = (sign == SIGN_NEG);
    sign_ok = neg || (sign == SIGN_POS);
    if (bad || !sign_ok) begin
      res.err = 1'b1;
    end else if (signed_mode &&
                 ((!neg && (acc > S_POS_MAX)) || (neg && (acc > S_NEG_MAX)))) begin
      res.ovf = 1'b1;
    end else if (!signed_mode && (acc > U_MAX)) begin
      res.ovf = 1'b1;
    end else if (!signed_mode && (neg != (acc >= S_NEG_MAX))) begin
      // unsigned words must carry the minus nibble exactly when bit 7 is set
      res.err = 1'b1;
    end else if (signed_mode && neg) begin
      res.number = ~acc[7:0] + 8'd1;
    end else begin
      res.number = acc[7:0];
    end
    return res;
  endfunction

endpackage

// File: rtl/bcd_digit_mac.sv
// Combinational decimal multiply-accumulate step: acc_o = acc_i*10 + digit_i.
// Ports: acc_i (10b running value), digit_i (BCD nibble),
//        acc_o (10b updated value), digit_ok_o (digit_i is 0..9).
module bcd_digit_mac
  import bcd_pkg::*;
(
  input  logic [9:0] acc_i,
  input  logic [3:0] digit_i,
  output logic [9:0] acc_o,
  output logic       digit_ok_o
);

  always_comb begin
    // *10 as shift-and-add; only malformed digits can wrap, and those are flagged
    acc_o      = (acc_i << 3) + (acc_i << 1) + {6'b0, digit_i};
    digit_ok_o = (digit_i <= DIGIT_MAX);
  end

endmodule

// File: rtl/bcd_to_bits.sv
// Sequential sign+3-digit packed BCD to 8-bit binary decoder.
// Ports: clk, rst_n (async active-low); in_valid/in_ready + bits[15:0] +
//        signed_flg input handshake; out_valid/out_ready output handshake with
//        number[7:0], err (malformed word), ovf (outside 8-bit range).
module bcd_to_bits
  import bcd_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] bits,
  input  logic        signed_flg,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  number,
  output logic        err,
  output logic        ovf
);

  localparam logic [1:0] LAST_DIG = 2'(NDIG - 1);

  state_e      state_q, state_d;
  logic [15:0] word_q, word_d;
  logic        sgn_q, sgn_d;
  logic [9:0]  acc_q, acc_d;
  logic [1:0]  cnt_q, cnt_d;
  logic        bad_q, bad_d;
  logic [7:0]  number_q, number_d;
  logic        err_q, err_d;
  logic        ovf_q, ovf_d;

  logic [3:0]  digit;
  logic [9:0]  mac_acc;
  logic        digit_ok;
  result_t     fix_res;

  // hundreds first
  always_comb begin
    digit = word_q[3:0];
    case (cnt_q)
      2'd0:    digit = word_q[11:8];
      2'd1:    digit = word_q[7:4];
      default: digit = word_q[3:0];
    endcase
  end

  bcd_digit_mac u_mac (
    .acc_i      (acc_q),
    .digit_i    (digit),
    .acc_o      (mac_acc),
    .digit_ok_o (digit_ok)
  );

  always_comb begin
    fix_res = '0;
    fix_res = fix_result(acc_q, word_q[15:12], sgn_q, bad_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      word_q   <= '0;
      sgn_q    <= 1'b0;
      acc_q    <= '0;
      cnt_q    <= '0;
      bad_q    <= 1'b0;
      number_q <= '0;
      err_q    <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      word_q   <= word_d;
      sgn_q    <= sgn_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      bad_q    <= bad_d;
      number_q <= number_d;
      err_q    <= err_d;
      ovf_q    <= ovf_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    word_d   = word_q;
    sgn_d    = sgn_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    bad_d    = bad_q;
    number_d = number_q;
    err_d    = err_q;
    ovf_d    = ovf_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          state_d = ST_ACC;
          word_d  = bits;
          sgn_d   = signed_flg;
          acc_d   = '0;
          cnt_d   = '0;
          bad_d   = 1'b0;
        end
      end
      ST_ACC: begin
        acc_d = mac_acc;
        bad_d = bad_q | ~digit_ok;
        cnt_d = cnt_q + 2'd1;
        if (cnt_q == LAST_DIG) state_d = ST_FIX;
      end
      ST_FIX: begin
        number_d = fix_res.number;
        err_d    = fix_res.err;
        ovf_d    = fix_res.ovf;
        state_d  = ST_DONE;
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == ST_IDLE);
    out_valid = (state_q == ST_DONE);
    number    = number_q;
    err       = err_q;
    ovf       = ovf_q;
  end

endmodule

// File: tb/tb_bcd_to_bits.sv
module tb_bcd_to_bits;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] bits;
  logic        signed_flg;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  number;
  logic        err;
  logic        ovf;

  int checks = 0;
  int errors = 0;

  bcd_to_bits dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .bits       (bits),
    .signed_flg (signed_flg),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .number     (number),
    .err        (err),
    .ovf        (ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: {number, err, ovf} from the decimal value of the word.
  function automatic logic [9:0] model(input logic [15:0] w, input logic sgn);
    int  h, t, o, val;
    bit  neg, pos;
    h   = int'(w[11:8]);
    t   = int'(w[7:4]);
    o   = int'(w[3:0]);
    neg = (w[15:12] == 4'hA);
    pos = (w[15:12] == 4'hF);
    val = 100 * h + 10 * t + o;
    if (h > 9 || t > 9 || o > 9 || !(neg || pos)) return {8'h00, 1'b1, 1'b0};
    if (sgn) begin
      if (neg ? (val > 128) : (val > 127)) return {8'h00, 1'b0, 1'b1};
      return {(neg ? 8'(-val) : 8'(val)), 1'b0, 1'b0};
    end
    if (val > 255) return {8'h00, 1'b0, 1'b1};
    if (neg != (val >= 128)) return {8'h00, 1'b1, 1'b0};
    return {8'(val), 1'b0, 1'b0};
  endfunction

  task automatic run_word(input logic [15:0] w, input logic sgn, input int hold);
    logic [9:0] exp;
    int         n;
    string      tag;
    exp = model(w, sgn);
    tag = $sformatf("%h/%0d", w, sgn);
    @(negedge clk);
    check({tag, " in_ready idle"}, 32'(in_ready), 1);
    in_valid   = 1'b1;
    bits       = w;
    signed_flg = sgn;
    out_ready  = (hold == 0);
    @(negedge clk);
    n = 0;
    while (!out_valid && n < 12) begin
      check({tag, " in_ready busy"}, 32'(in_ready), 0);
      in_valid   = 1'b1;
      bits       = 16'($urandom);
      signed_flg = 1'($urandom);
      @(negedge clk);
      n++;
    end
    check({tag, " latency"}, 32'(n), 4);
    check({tag, " number"}, 32'(number), 32'(exp[9:2]));
    check({tag, " err"}, 32'(err), 32'(exp[1]));
    check({tag, " ovf"}, 32'(ovf), 32'(exp[0]));
    for (int i = 0; i < hold; i++) begin
      check({tag, " in_ready done"}, 32'(in_ready), 0);
      in_valid = 1'b1;
      bits     = 16'($urandom);
      @(negedge clk);
      check({tag, " hold valid"}, 32'(out_valid), 1);
      check({tag, " hold number"}, 32'(number), 32'(exp[9:2]));
    end
    out_ready = 1'b1;
    @(negedge clk);
    check({tag, " valid drop"}, 32'(out_valid), 0);
    check({tag, " in_ready back"}, 32'(in_ready), 1);
    check({tag, " number kept"}, 32'(number), 32'(exp[9:2]));
    out_ready = 1'b0;
    in_valid  = 1'b0;
  endtask

  logic [15:0] dir_w [15];
  logic        dir_s [15];

  initial begin
    clk        = 1'b0;
    rst_n      = 1'b0;
    in_valid   = 1'b0;
    bits       = '0;
    signed_flg = 1'b0;
    out_ready  = 1'b0;

    #2;
    check("reset in_ready", 32'(in_ready), 1);
    check("reset out_valid", 32'(out_valid), 0);
    check("reset number", 32'(number), 0);
    check("reset err", 32'(err), 0);
    check("reset ovf", 32'(ovf), 0);
    #20 rst_n = 1'b1;

    dir_w = '{16'hF127, 16'hA128, 16'hA001, 16'hA000, 16'hA255, 16'hF255, 16'hF099,
              16'hF128, 16'hA129, 16'hF999, 16'hF1A3, 16'hB012, 16'hAB99, 16'hA127,
              16'hF000};
    dir_s = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0,
              1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0,
              1'b0};
    for (int i = 0; i < 15; i++) run_word(dir_w[i], dir_s[i], (i == 0) ? 5 : (i % 3));

    // reset in the middle of accumulation
    @(negedge clk);
    in_valid   = 1'b1;
    bits       = 16'hA005;
    signed_flg = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst out_valid", 32'(out_valid), 0);
    check("midrst in_ready", 32'(in_ready), 1);
    check("midrst number", 32'(number), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("postrst out_valid", 32'(out_valid), 0);
    run_word(16'hF042, 1'b1, 1);

    for (int i = 0; i < 40; i++) begin
      logic [15:0] w;
      int          r;
      r = int'($urandom_range(0, 9));
      w[15:12] = (r == 0) ? 4'($urandom) : ((r < 5) ? 4'hA : 4'hF);
      w[11:8]  = ($urandom_range(0, 9) == 0) ? 4'($urandom) : 4'($urandom_range(0, 2));
      w[7:4]   = ($urandom_range(0, 9) == 0) ? 4'($urandom) : 4'($urandom_range(0, 9));
      w[3:0]   = ($urandom_range(0, 9) == 0) ? 4'($urandom) : 4'($urandom_range(0, 9));
      run_word(w, 1'($urandom), int'($urandom_range(0, 3)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bcd_to_bits.md
# bcd_to_bits

Sequential BCD-to-binary decoder, the inverse of the bits generator. It accepts a 16-bit sign-plus-3-digit packed BCD word and reconstructs the 8-bit two's-complement or unsigned number. It sits on the input side of the display/entry path, behind a valid/ready handshake, and flags malformed words and out-of-range values.

## Interface
- No parameters. The word format is fixed: sign nibble plus 3 BCD digits, giving an 8-bit result.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `in_valid` in 1: `bits`/`signed_flg` valid.
- `in_ready` out 1: block can accept a word (IDLE only).
- `bits` in 16: [15:12] sign nibble (4'hA = minus, 4'hF = plus); [11:8] hundreds, [7:4] tens, [3:0] ones.
- `signed_flg` in 1: 1 = decode as signed 8-bit; 0 = unsigned 8-bit.
- `out_valid` out 1: result valid; held until accepted.
- `out_ready` in 1: consumer accepts result.
- `number` out 8: decoded value.
- `err` out 1: malformed word.
- `ovf` out 1: value outside 8-bit range.

## Operation
- FSM states: IDLE, ACC, FIX, DONE.
- **IDLE:** `in_ready`=1. On `in_valid`&`in_ready`, capture `bits`/`signed_flg`, clear accumulator (10-bit, max 999), go to ACC.
- **ACC:** 3 cycles, one digit per cycle, hundreds first. Update is acc = acc*10 + d, with *10 implemented as (acc<<3)+(acc<<1), 10-bit, no truncation possible.
  - A digit > 9 sets a sticky internal `bad` flag; accumulation continues.
- **FIX:** evaluate in priority order; the first match wins.
  1. `err`: `bad`, or sign nibble not A/F.
  2. `ovf`, signed: plus with acc > 127, or minus with acc > 128.
  3. `ovf`, unsigned: acc > 255.
  4. `err`, unsigned mode only: sign nibble inconsistent with result bit 7. A is required iff acc ≥ 128.
  5. Otherwise, signed: `number` = minus ? (~acc[7:0] + 1) : acc[7:0]. Unsigned: `number` = acc[7:0].
  - On `err` or `ovf`, `number`=8'h00 and the other flag is 0.
  - "A000" in signed mode is legal and decodes to 8'h00.
  - Go to DONE.
- **DONE:** `out_valid`=1; `number`/`err`/`ovf` stable. On `out_ready`, return to IDLE and drop `out_valid`.
- `in_ready`=0 in ACC, FIX and DONE. Inputs are ignored outside IDLE.

## Timing
- Reset (async, immediate): state IDLE, `in_ready`=1, `out_valid`=0, `number`=8'h00, `err`=0, `ovf`=0, accumulator 0.
- Reset mid-operation aborts the word; no result is produced.
- Latency: handshake edge T0 → `out_valid` high after edge T4, i.e. visible in the cycle following T4.
  - T1–T3: digits.
  - T4: FIX.
- `out_ready` may already be high when `out_valid` rises: 1-cycle DONE, back in IDLE after T5.
- Throughput: one word per 6 cycles minimum.
- Outputs are registered; `in_ready` is a decode of the state register.
- `out_valid` deasserts on the edge where `out_valid`&`out_ready`. `number`/`err`/`ovf` hold their last value until the next FIX.

## Structure
- Shared package/header `bcd_pkg`, holding:
  - `SIGN_NEG`=4'hA, `SIGN_POS`=4'hF.
  - `NDIG`=3.
  - FSM state encoding (2 bits).
  - Range constants 127/128/255.
  - The bits generator uses the same sign constants.
- One sub-module, `bcd_digit_mac`: combinational acc*10 + d, plus a digit-valid (≤9) output. It is instantiated once in the top FSM.

## Test plan
- Signed 16'hF127 → `number`=8'h7F, `err`=0, `ovf`=0. `out_valid` rises exactly 4 cycles after the handshake edge; `in_ready`=0 throughout.
- Signed 16'hA128 → 8'h80; signed 16'hA001 → 8'hFF; signed 16'hA000 → 8'h00, no flags.
- Unsigned 16'hA255 → 8'hFF. Unsigned 16'hF255 → `err`=1, `number`=8'h00 (sign mismatch). Unsigned 16'hF099 → 8'h63.
- Signed 16'hF128 → `ovf`=1, `number`=8'h00. Signed 16'hA129 → `ovf`=1. Unsigned 16'hF999 → `ovf`=1.
- Malformed words, each giving `err`=1, `ovf`=0, `number`=8'h00:
  - 16'hF1A3 (bad digit).
  - 16'hB012 (bad sign).
  - 16'hAB99 (bad digit beats overflow).
- Backpressure and reset:
  - Hold `out_ready`=0 for 5 cycles → `out_valid`/`number` stable, `in_ready`=0, new `in_valid` ignored.
  - Assert `rst_n`=0 during ACC → `out_valid`=0 and `in_ready`=1 immediately.
  - After release, 16'hF042 decodes to 8'h2A.
